// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the iterative shift-add multiplier
package seq_mult_pkg;

    // Controller states, held in two bits.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Width of the CALC-cycle counter: it must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_n.sv
// rtl/seq_mult_n.sv - parametrised iterative shift-add multiplier with start/busy/done handshake
//
// Multiplies two WIDTH-bit operands, unsigned or two's complement, one
// multiplier bit per cycle, and optionally stops early once the remaining
// multiplier bits are zero.
//
// Ports:
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   start        request, sampled only while idle
//   signed_mode  1 = operands/product are two's complement, sampled with start
//   dataa        multiplicand, sampled with start
//   datab        multiplier, sampled with start
//   busy         high from the accepting edge through the finishing edge
//   done         one-cycle pulse, result valid from this cycle
//   result       2*WIDTH-bit product, held until the next done
module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int              CW       = cnt_w(WIDTH);
    localparam int              PW       = 2 * WIDTH;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     result_q, result_d;
    logic [WIDTH-1:0]  mb_q, mb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  ma_in;
    logic [WIDTH-1:0]  mb_in;
    logic [WIDTH-1:0]  mb_shift;
    logic [CW-1:0]     cnt_inc;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
    // still fits because the magnitude is treated as unsigned from here on.
    always_comb begin
        ma_in    = (signed_mode && dataa[WIDTH-1]) ? (~dataa + WIDTH'(1)) : dataa;
        mb_in    = (signed_mode && datab[WIDTH-1]) ? (~datab + WIDTH'(1)) : datab;
        mb_shift = mb_q >> 1;
        cnt_inc  = cnt_q + CW'(1);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        mb_d     = mb_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, ma_in};
                    mb_d    = mb_in;
                    cnt_d   = '0;
                    neg_d   = signed_mode && (dataa[WIDTH-1] ^ datab[WIDTH-1]);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // The accumulator is 2*WIDTH bits wide, so the sum of shifted
                // partial products can never overflow it.
                if (mb_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mb_d    = mb_shift;
                cnt_d   = cnt_inc;
                // Testing the shifted multiplier guarantees at least one CALC
                // cycle even when the multiplier is zero.
                if ((cnt_inc == CNT_LAST) || (EARLY_TERM && (mb_shift == '0))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                result_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            mb_q     <= mb_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// tb/tb_seq_mult_n.sv - self-checking bench for seq_mult_n with early-termination and fixed-length instances
module tb_seq_mult_n;

    localparam int W = 18;

    logic            clk;
    logic            rst_n;
    logic            start_e, start_n;
    logic            signed_mode;
    logic [W-1:0]    dataa, datab;
    logic            busy_e, done_e, busy_n, done_n;
    logic [2*W-1:0]  result_e, result_n;

    int checks = 0;
    int errors = 0;

    seq_mult_n #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_e (
        .CLK(clk), .RST_N(rst_n), .start(start_e), .signed_mode(signed_mode),
        .dataa(dataa), .datab(datab), .busy(busy_e), .done(done_e), .result(result_e)
    );

    seq_mult_n #(.WIDTH(W), .EARLY_TERM(1'b0)) dut_n (
        .CLK(clk), .RST_N(rst_n), .start(start_n), .signed_mode(signed_mode),
        .dataa(dataa), .datab(datab), .busy(busy_n), .done(done_n), .result(result_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product using plain integer arithmetic.
    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
        longint pa, pb, p;
        if (sm) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Edges from accept to the done cycle: CALC cycles plus the finishing edge.
    function automatic int model_lat(input logic [W-1:0] b, input bit sm, input bit et);
        int v, n;
        if (!et) return W + 1;
        v = sm ? int'($signed(b)) : int'(b);
        if (v < 0) v = -v;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        if (n == 0) n = 1;
        return n + 1;
    endfunction

    task automatic run_op(input bit et, input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                          output logic [2*W-1:0] res, output int lat, output bit busy_after);
        @(negedge clk);
        dataa = a; datab = b; signed_mode = sm;
        if (et) start_e = 1'b1; else start_n = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0; start_n = 1'b0;
        busy_after = et ? busy_e : busy_n;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (et ? done_e : done_n) begin
                lat = k;
                res = et ? result_e : result_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_e = 1'b0; start_n = 1'b0;
        signed_mode = 1'b0; dataa = '0; datab = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_e, done_e, busy_n, done_n} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {busy_e, done_e, busy_n, done_n});
        end
        checks++;
        if (result_e !== '0 || result_n !== '0) begin
            errors++; $display("FAIL reset_result got %h/%h want 0", result_e, result_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [7];
        logic [W-1:0]   tb [7];
        bit             ts [7];
        bit             te [7];
        logic [2*W-1:0] exp_r [7];
        int             exp_l [7];
        logic [2*W-1:0] res;
        int             lat;
        bit             ba;
        ta = '{18'd3, 18'h3FFFF, 18'h3FFF9, 18'h20000, 18'd12345, 18'd12345, 18'd5};
        tb = '{18'd5, 18'h3FFFF, 18'd6,     18'h20000, 18'd0,     18'd0,     18'd3};
        ts = '{0, 0, 1, 1, 0, 0, 0};
        te = '{1, 1, 1, 1, 1, 0, 0};
        exp_r = '{36'd15, 36'hFFFF80001, 36'hFFFFFFFD6, 36'h400000000, 36'd0, 36'd0, 36'd15};
        exp_l = '{4, 19, 4, 19, 2, 19, 19};
        for (int i = 0; i < 7; i++) begin
            run_op(te[i], ta[i], tb[i], ts[i], res, lat, ba);
            checks++;
            if (ba !== 1'b1) begin
                errors++; $display("FAIL dir%0d_busy got %b want 1", i, ba);
            end
            checks++;
            if (res !== exp_r[i]) begin
                errors++; $display("FAIL dir%0d_result got %h want %h", i, res, exp_r[i]);
            end
            checks++;
            if (lat != exp_l[i]) begin
                errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_l[i]);
            end
            checks++;
            if ((te[i] ? busy_e : busy_n) !== 1'b0) begin
                errors++; $display("FAIL dir%0d_busy_with_done got 1 want 0", i);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b, msk;
        bit             sm, et;
        logic [2*W-1:0] res;
        int             lat;
        bit             ba;
        for (int i = 0; i < 24; i++) begin
            a   = W'($urandom);
            msk = W'((32'h1 << $urandom_range(0, W)) - 1);
            b   = W'($urandom) & msk;
            if ($urandom_range(0, 3) == 0) b = ~b;
            sm  = 1'($urandom);
            et  = (i % 3) != 0;
            run_op(et, a, b, sm, res, lat, ba);
            checks++;
            if (res !== model_prod(a, b, sm)) begin
                errors++; $display("FAIL rand%0d_result a=%h b=%h s=%0d got %h want %h", i, a, b, sm, res, model_prod(a, b, sm));
            end
            checks++;
            if (lat != model_lat(b, sm, et)) begin
                errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, model_lat(b, sm, et));
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [2*W-1:0] expv;
        int             lat;
        bit             extra;
        expv = model_prod(18'd100, 18'h20000, 1'b0);
        @(negedge clk);
        dataa = 18'd100; datab = 18'h20000; signed_mode = 1'b0; start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dataa = 18'd7; datab = 18'd9; signed_mode = 1'b1; start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        lat = -1;
        for (int k = 5; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done_e) begin lat = k; break; end
        end
        checks++;
        if (lat != 19) begin
            errors++; $display("FAIL ignore_latency got %0d want 19", lat);
        end
        checks++;
        if (result_e !== expv) begin
            errors++; $display("FAIL ignore_result got %h want %h", result_e, expv);
        end
        extra = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done_e || busy_e) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0 || result_e !== expv) begin
            errors++; $display("FAIL ignore_no_requeue got extra=%0d result=%h want 0/%h", extra, result_e, expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];
        bit           bs [3];
        int           lat;
        ba = '{18'd3, 18'd7, 18'h3FFF9};
        bb = '{18'd5, 18'h1F, 18'd6};
        bs = '{0, 0, 1};
        @(negedge clk);
        dataa = ba[0]; datab = bb[0]; signed_mode = bs[0]; start_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy_e !== 1'b1) begin
                errors++; $display("FAIL b2b%0d_accept got busy=%b want 1", i, busy_e);
            end
            lat = -1;
            for (int k = 1; k <= 60; k++) begin
                @(posedge clk); #1;
                if (done_e) begin lat = k; break; end
            end
            checks++;
            if (lat != model_lat(bb[i], bs[i], 1'b1)) begin
                errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, model_lat(bb[i], bs[i], 1'b1));
            end
            checks++;
            if (result_e !== model_prod(ba[i], bb[i], bs[i])) begin
                errors++; $display("FAIL b2b%0d_result got %h want %h", i, result_e, model_prod(ba[i], bb[i], bs[i]));
            end
            if (i < 2) begin
                dataa = ba[i+1]; datab = bb[i+1]; signed_mode = bs[i+1];
            end else begin
                start_e = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_e !== 1'b0) begin
            errors++; $display("FAIL b2b_stop got busy=%b want 0", busy_e);
        end
    endtask

    task automatic test_reset_mid();
        bit             seen;
        logic [2*W-1:0] res;
        int             lat;
        bit             ba;
        @(negedge clk);
        dataa = 18'd999; datab = 18'h20001; signed_mode = 1'b0; start_e = 1'b1; start_n = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0; start_n = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_e, done_e, busy_n, done_n} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_flags got %b want 0000", {busy_e, done_e, busy_n, done_n});
        end
        checks++;
        if (result_e !== '0 || result_n !== '0) begin
            errors++; $display("FAIL rstmid_result got %h/%h want 0", result_e, result_n);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done_e || done_n) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done got %b want 0", seen);
        end
        run_op(1'b1, 18'h2ABCD, 18'h3FF00, 1'b1, res, lat, ba);
        checks++;
        if (res !== model_prod(18'h2ABCD, 18'h3FF00, 1'b1)) begin
            errors++; $display("FAIL rstmid_after got %h want %h", res, model_prod(18'h2ABCD, 18'h3FF00, 1'b1));
        end
        checks++;
        if (lat != model_lat(18'h3FF00, 1'b1, 1'b1)) begin
            errors++; $display("FAIL rstmid_after_latency got %0d want %0d", lat, model_lat(18'h3FF00, 1'b1, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
